imm_splitter: RTL and testbench
===============================

// Module: imm_splitter
// PURPOSE
//  Inverse of the immediate extender. Takes an 8- or 16-bit operand and emits it
//  MSB-first as a stream of 6-bit immediate chunks over a valid/ready handshake.
//  Each chunk is the top IMM_W bits of the working word, so a short final chunk
//  is left-aligned and zero-padded. Re-extending the chunks at their word
//  positions therefore rebuilds the operand. Sits between the constant or
//  register source and the immediate-field encoder of the instruction builder.
// PARAMETERS
//  DATA_W    16  wide operand width (control=1)
//  NARROW_W   8  narrow operand width (control=0), taken from in_data[NARROW_W-1:0]
//  IMM_W      6  chunk width; chunk counts are ceil(W/IMM_W): 3 for wide, 2 for narrow
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       operand offered
//  in_ready   out  1       operand accepted when in_valid && in_ready
//  in_data    in   DATA_W  operand; narrow mode uses [NARROW_W-1:0] only
//  in_wide    in   1       1 = DATA_W operand, 0 = NARROW_W operand
//  out_valid  out  1       chunk available
//  out_ready  in   1       consumer takes chunk when out_valid && out_ready
//  out_imm    out  IMM_W   current chunk
//  out_idx    out  2       chunk index within operand, 0 = MSB chunk
//  out_last   out  1       current chunk is the operand's final chunk
//  busy       out  1       operand in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, shreg=0, cnt=0, idx=0. Outputs:
//    out_valid=0, out_imm=0, out_idx=0, out_last=0, busy=0.
//  - FSM has two states, IDLE and EMIT.
//  - IDLE -> EMIT on input handshake. Load rules:
//    shreg = in_wide ? in_data : {in_data[NARROW_W-1:0], {DATA_W-NARROW_W{0}}}
//    cnt = in_wide ? 3 : 2, idx = 0.
//  - In EMIT: out_valid=1, out_imm=shreg[DATA_W-1 -: IMM_W], out_idx=idx,
//    out_last=(cnt==1).
//  - On output handshake with !out_last: shreg <= shreg << IMM_W (zero fill),
//    cnt--, idx++.
//  - On output handshake with out_last: return to IDLE unless a new operand is
//    accepted in the same cycle.
//  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This path
//    is combinational from out_ready by design.
//  - Simultaneous last-chunk handshake and in_valid: load the new operand that
//    cycle and stay in EMIT. out_valid does not drop (no bubble). Peak rate is
//    one chunk per cycle.
//  - Latency: first chunk is valid the cycle after input acceptance (registered).
//  - Backpressure: while out_valid && !out_ready, out_imm, out_idx and out_last
//    hold stable. in_data and in_wide are ignored outside the acceptance cycle.
//  - in_wide is sampled only at acceptance; a change mid-operand has no effect.
//  - Chunk mapping (wide): [15:10], [9:4], {[3:0], 2'b00}.
//    Chunk mapping (narrow): [7:2], {[1:0], 4'b0000}.
//  - Reset asserted mid-operand: the partial operand is discarded, outputs are
//    cleared immediately, and there is no replay after reset releases.
//  - X on in_data with in_valid=0 never propagates to out_imm.
// STRUCTURE
//  - Shared package: IMM_W, NARROW_W, DATA_W, chunk-count constants
//    (WIDE_CHUNKS=3, NARROW_CHUNKS=2), state encoding (IDLE=1'b0, EMIT=1'b1).
//    The extender uses the same package.
//  - Single module with no sub-module. The shift register, down-counter and
//    2-state FSM are inline.
// TESTING
//  1. Wide 16'hABCD, out_ready=1 -> 0x2A/idx0, 0x3C/idx1, 0x34/idx2+last on
//     consecutive cycles, then busy=0.
//  2. Narrow 8'hB7 (in_data=16'h12B7, in_wide=0) -> 0x2D/idx0, 0x30/idx1+last;
//     upper byte 0x12 never appears.
//  3. Back-to-back: 16'hFFFF then 8'h01 with in_valid held ->
//     0x3F, 0x3F, 0x3C+last, then 0x00, 0x10+last.
//     in_ready pulses on the last-chunk cycle and there is no out_valid gap.
//  4. Backpressure: wide 16'h8001, out_ready low for 3 cycles at idx1 ->
//     out_imm=0x00 and idx=1 stay stable; the sequence resumes 0x00, 0x04+last.
//  5. Reset mid-op: assert rst_n=0 after the first chunk of 16'hABCD ->
//     out_valid=0 and busy=0 asynchronously. After release in_ready=1, and a new
//     8'hB7 yields 0x2D, 0x30.
//  6. Round-trip scoreboard: random operands and modes with random out_ready ->
//     OR of the zero-extended chunks placed at their positions equals the
//     original operand.

Source files
------------

// File: rtl/imm_splitter_pkg.sv
// Shared constants and state encoding for the immediate splitter and extender.
package imm_splitter_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned NARROW_W      = 8;
  localparam int unsigned IMM_W         = 6;
  localparam int unsigned WIDE_CHUNKS   = 3;
  localparam int unsigned NARROW_CHUNKS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Number of IMM_W chunks needed to cover a w-bit operand.
  function automatic int unsigned chunk_count(input int unsigned w, input int unsigned imm);
    return (w + imm - 1) / imm;
  endfunction

endpackage

// File: rtl/imm_splitter.sv
// Streams an 8- or 16-bit operand MSB-first as left-aligned, zero-padded
// IMM_W-bit chunks over a valid/ready handshake.
module imm_splitter #(
  parameter int unsigned DATA_W   = imm_splitter_pkg::DATA_W,
  parameter int unsigned NARROW_W = imm_splitter_pkg::NARROW_W,
  parameter int unsigned IMM_W    = imm_splitter_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wide,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  import imm_splitter_pkg::state_t;
  import imm_splitter_pkg::IDLE;
  import imm_splitter_pkg::EMIT;
  import imm_splitter_pkg::chunk_count;

  localparam int unsigned WIDE_N   = chunk_count(DATA_W, IMM_W);
  localparam int unsigned NARROW_N = chunk_count(NARROW_W, IMM_W);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [1:0]        r_idx;
  logic [1:0]        w_idx_nxt;
  logic              w_emit;
  logic              w_last;
  logic              w_out_hs;
  logic              w_in_ready;
  logic              w_accept;

  always_comb begin
    w_emit      = (r_state == EMIT);
    w_last      = w_emit && (r_cnt == 2'd1);
    w_out_hs    = w_emit && out_ready;
    w_in_ready  = (r_state == IDLE) || (w_out_hs && w_last);
    w_accept    = in_valid && w_in_ready;
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    // A new operand wins over the last-chunk retire, so EMIT continues without a bubble.
    if (w_accept) begin
      w_state_nxt = EMIT;
      w_shreg_nxt = in_wide ? in_data
                            : {in_data[NARROW_W-1:0], {(DATA_W-NARROW_W){1'b0}}};
      w_cnt_nxt   = in_wide ? 2'(WIDE_N) : 2'(NARROW_N);
      w_idx_nxt   = '0;
    end else if (w_out_hs) begin
      if (w_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_shreg_nxt = r_shreg << IMM_W;
        w_cnt_nxt   = r_cnt - 2'd1;
        w_idx_nxt   = r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Gate the datapath in IDLE so stale shift-register contents stay hidden.
  assign in_ready  = w_in_ready;
  assign out_valid = w_emit;
  assign out_imm   = w_emit ? r_shreg[DATA_W-1 -: IMM_W] : '0;
  assign out_idx   = w_emit ? r_idx : '0;
  assign out_last  = w_last;
  assign busy      = w_emit;

endmodule

// File: tb/tb_imm_splitter.sv
// Directed vector table, hand-written corner sequences and a randomized
// round-trip scoreboard for imm_splitter.
module tb_imm_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_wide = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_imm;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  imm_splitter #(.DATA_W(16), .NARROW_W(8), .IMM_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_wide(in_wide),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive just after the rising edge, then move to the falling edge for sampling.
  task automatic drive(input logic v, input logic [15:0] d, input logic w, input logic r);
    in_valid  = v;
    in_data   = d;
    in_wide   = w;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference chunking: pad the operand on the right up to a multiple of 6 bits
  // and cut it into 6-bit slices from the top.
  typedef struct { int imm; int idx; int last; } chunk_t;
  chunk_t exp_q[$];
  typedef struct { int data; int wide; } op_t;
  op_t op_q[$];

  function automatic int model_n(input int wide);
    return wide ? 3 : 2;
  endfunction

  function automatic int model_chunk(input int data, input int wide, input int i);
    int padw;
    int val;
    padw = 6 * model_n(wide);
    val  = wide ? ((data & 16'hFFFF) * 4) : ((data & 8'hFF) * 16);
    return (val >> (padw - 6 * (i + 1))) & 63;
  endfunction

  typedef struct {
    logic [15:0] data;
    logic        wide;
    int          n;
    int          c[3];
  } vec_t;

  int          acc;
  int          prev_hold;
  logic [5:0]  prev_imm;
  logic [1:0]  prev_idx;
  logic        prev_last;

  // One scoreboarded cycle: sample handshakes on the falling edge.
  task automatic sb_cycle(input logic v, input logic [15:0] d, input logic w, input logic r);
    chunk_t e;
    op_t    o;
    int     padw;
    drive(v, d, w, r);
    if (prev_hold) begin
      chk("hold_imm", out_imm, prev_imm);
      chk("hold_idx", out_idx, prev_idx);
      chk("hold_last", out_last, prev_last);
    end
    prev_hold = out_valid && !out_ready;
    prev_imm  = out_imm;
    prev_idx  = out_idx;
    prev_last = out_last;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0 || op_q.size() == 0) begin
        chk("spurious_chunk", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rnd_imm", out_imm, e.imm);
        chk("rnd_idx", out_idx, e.idx);
        chk("rnd_last", out_last, e.last);
        o = op_q[0];
        padw = 6 * model_n(o.wide);
        acc = acc | (int'(out_imm) << (padw - 6 * (int'(out_idx) + 1)));
        if (out_last) begin
          chk("roundtrip", acc >> (o.wide ? 2 : 4), o.wide ? o.data & 16'hFFFF : o.data & 8'hFF);
          acc = 0;
          void'(op_q.pop_front());
        end
      end
    end
    if (in_valid && in_ready) begin
      o.data = int'(in_data);
      o.wide = int'(in_wide);
      op_q.push_back(o);
      for (int i = 0; i < model_n(o.wide); i++) begin
        e.imm  = model_chunk(o.data, o.wide, i);
        e.idx  = i;
        e.last = (i == model_n(o.wide) - 1) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
    next_cycle();
  endtask

  vec_t vecs[5];

  initial begin
    int          total;
    int          sent;
    int          budget;
    logic        pend;
    logic [15:0] pd;
    logic        pw;

    vecs[0] = '{16'hABCD, 1'b1, 3, '{'h2A, 'h3C, 'h34}};
    vecs[1] = '{16'h12B7, 1'b0, 2, '{'h2D, 'h30, 0}};
    vecs[2] = '{16'h8001, 1'b1, 3, '{'h20, 'h00, 'h04}};
    vecs[3] = '{16'hFFFF, 1'b1, 3, '{'h3F, 'h3F, 'h3C}};
    vecs[4] = '{16'hFF01, 1'b0, 2, '{'h00, 'h10, 0}};

    // Reset state
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    next_cycle();

    // Vector table, one operand at a time with out_ready high.
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].data, vecs[k].wide, 1'b1);
      chk("vec_accept", in_ready, 1);
      next_cycle();
      for (int i = 0; i < vecs[k].n; i++) begin
        drive(1'b0, 16'h5A5A, ~vecs[k].wide, 1'b1);
        chk("vec_valid", out_valid, 1);
        chk("vec_imm", out_imm, vecs[k].c[i]);
        chk("vec_idx", out_idx, i);
        chk("vec_last", out_last, (i == vecs[k].n - 1) ? 1 : 0);
        next_cycle();
      end
      @(negedge clk);
      chk("vec_busy_after", busy, 0);
      chk("vec_valid_after", out_valid, 0);
      chk("vec_imm_after", out_imm, 0);
      next_cycle();
    end

    // Back-to-back: FFFF wide, then narrow 01 held on in_valid.
    drive(1'b1, 16'hFFFF, 1'b1, 1'b1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0001, 1'b0, 1'b1);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_imm", out_imm, (i == 2) ? 'h3C : 'h3F);
      chk("b2b_in_ready", in_ready, (i == 2) ? 1 : 0);
      chk("b2b_last", out_last, (i == 2) ? 1 : 0);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h0001, 1'b0, 1'b1);
      chk("b2b2_valid", out_valid, 1);
      chk("b2b2_imm", out_imm, (i == 1) ? 'h10 : 'h00);
      chk("b2b2_idx", out_idx, i);
      chk("b2b2_last", out_last, i);
      next_cycle();
    end
    @(negedge clk);
    chk("b2b_busy_after", busy, 0);
    next_cycle();

    // Backpressure at idx1 of 8001.
    drive(1'b1, 16'h8001, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_imm0", out_imm, 'h20);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234, 1'b0, 1'b0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_imm", out_imm, 'h00);
      chk("bp_hold_idx", out_idx, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      next_cycle();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_res_imm1", out_imm, 'h00);
    chk("bp_res_idx1", out_idx, 1);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_res_imm2", out_imm, 'h04);
    chk("bp_res_last", out_last, 1);
    next_cycle();

    // Reset mid-operand.
    drive(1'b1, 16'hABCD, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("rmid_imm0", out_imm, 'h2A);
    next_cycle();
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_valid_async", out_valid, 0);
    chk("rmid_busy_async", busy, 0);
    chk("rmid_imm_async", out_imm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("rmid_in_ready", in_ready, 1);
    chk("rmid_no_replay", out_valid, 0);
    next_cycle();
    drive(1'b1, 16'h00B7, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("rmid_new_imm0", out_imm, 'h2D);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("rmid_new_imm1", out_imm, 'h30);
    chk("rmid_new_last", out_last, 1);
    next_cycle();

    // Randomized round trip with random backpressure.
    total = 300;
    sent = 0;
    budget = 0;
    pend = 1'b0;
    pd = '0;
    pw = 1'b0;
    acc = 0;
    prev_hold = 0;
    while ((sent < total || pend || exp_q.size() != 0) && budget < 20000) begin
      if (!pend && sent < total && $urandom_range(3) != 0) begin
        pend = 1'b1;
        pd = 16'($urandom);
        pw = 1'($urandom);
      end
      sb_cycle(pend, pend ? pd : 16'($urandom), pend ? pw : 1'($urandom),
               1'($urandom_range(2) != 0));
      if (pend && op_q.size() != 0 && op_q[op_q.size()-1].data == int'(pd)
          && exp_q.size() != 0 && exp_q[exp_q.size()-1].last == 1 && !in_valid_seen_pending()) begin
        pend = 1'b0;
        sent++;
      end
      budget++;
    end
    chk("rnd_timeout", (budget < 20000) ? 1 : 0, 1);
    chk("rnd_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Tracks whether the pending operand was accepted in the last scoreboard cycle.
  logic accepted_last = 1'b0;
  always @(negedge clk) accepted_last <= in_valid && in_ready;

  function automatic logic in_valid_seen_pending();
    return !accepted_last;
  endfunction

endmodule
